// File: rtl/ex_div_ctrl.sv
`timescale 1ns/1ps
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in EX.
// Holds a stall request while iterating and pulses ready with LO/HI results.
module ex_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stallreq_for_div,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;

  // dvd_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    qbit     = ~diff[WIDTH];
    rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {dvd_q[WIDTH-2:0], qbit};
    abs_dvd  = (signed_div && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
    abs_dvs  = (signed_div && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (divisor == '0) begin
            state_d = S_DIVZERO;
            dvd_d   = dividend;
          end else begin
            state_d   = S_BUSY;
            dvd_d     = abs_dvd;
            dvs_d     = abs_dvs;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = signed_div & dividend[WIDTH-1];
          end
        end
      end
      S_DIVZERO: begin
        state_d = S_DONE;
        quo_d   = '1;
        rmd_d   = dvd_q;
      end
      S_BUSY: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          quo_d   = neg_quo_q ? ('0 - quo_next) : quo_next;
          rmd_d   = neg_rem_q ? ('0 - rem_next) : rem_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancellation wins over any transition and leaves published results untouched.
    if (annul) begin
      state_d = S_IDLE;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
    end
  end

  assign stallreq_for_div = ((state_q == S_IDLE) && start && !annul) ||
                            (state_q == S_BUSY) || (state_q == S_DIVZERO);
  assign ready     = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ex_div_ctrl: expected LO/HI pairs are queued at issue
// and checked when the ready pulse appears.
module tb_ex_div_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         annul;
  logic         stallreq_for_div;
  logic         ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  ex_div_ctrl #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .signed_div       (signed_div),
    .dividend         (dividend),
    .divisor          (divisor),
    .annul            (annul),
    .stallreq_for_div (stallreq_for_div),
    .ready            (ready),
    .quotient         (quotient),
    .remainder        (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, q64, r64;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (sd) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q64 = sa / sb;
      r64 = sa % sb;
      e.q = q64[31:0];
      e.r = r64[31:0];
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns at the negedge of the ready cycle.
  task automatic do_div(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    int   lat;
    exp_t e;
    lat = (b == '0) ? 2 : int'(W) + 1;
    sbq.push_back(model(sd, a, b));
    start      = 1'b1;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    for (int k = 0; k <= lat; k++) begin
      if (k == 1) begin
        dividend   = ~a;
        divisor    = b ^ 32'h5;
        signed_div = ~sd;
      end
      @(negedge clk);
      chk("stallreq", {31'b0, stallreq_for_div}, 32'(k < lat));
      chk("ready", {31'b0, ready}, 32'(k == lat));
      if (ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
      end
      if (k < lat) tick();
    end
  endtask

  task automatic finish_div();
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    logic [W-1:0] pq, pr, ra, rb;
    bit           rs;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0; annul = 1'b0;

    tick();
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_stall", {31'b0, stallreq_for_div}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_div(1'b0, 32'd100, 32'd7);
    chk("udiv_q_const", quotient, 32'd14);
    chk("udiv_r_const", remainder, 32'd2);
    finish_div();

    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("sdiv_q_const", quotient, 32'hFFFF_FFFD);
    chk("sdiv_r_const", remainder, 32'hFFFF_FFFF);
    finish_div();

    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    chk("sdiv2_r_const", remainder, 32'd1);
    finish_div();

    do_div(1'b0, 32'h1234, 32'd0);
    finish_div();

    // Annul mid-operation; results from the divide-by-zero must survive.
    pq = 32'hFFFF_FFFF;
    pr = 32'h1234;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd5000; divisor = 32'd3;
    for (int k = 0; k <= 40; k++) begin
      if (k == 10) annul = 1'b1;
      if (k == 11) begin annul = 1'b0; start = 1'b0; end
      @(negedge clk);
      if (k <= 10) chk("annul_stall_busy", {31'b0, stallreq_for_div}, 32'd1);
      else         chk("annul_stall_idle", {31'b0, stallreq_for_div}, 32'd0);
      chk("annul_ready", {31'b0, ready}, 32'd0);
      if (k > 10) begin
        chk("annul_quotient", quotient, pq);
        chk("annul_remainder", remainder, pr);
      end
      tick();
    end

    // annul beats start while idle
    start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    chk("annul_start_stall", {31'b0, stallreq_for_div}, 32'd0);
    tick();
    start = 1'b0; annul = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("annul_start_ready", {31'b0, ready}, 32'd0);
      chk("annul_start_stall2", {31'b0, stallreq_for_div}, 32'd0);
      tick();
    end

    // Signed overflow, then back-to-back with start held through DONE
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_q_const", quotient, 32'h8000_0000);
    chk("ovf_r_const", remainder, 32'd0);
    tick();
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10);
    chk("b2b_q_const", quotient, 32'h0FFF_FFFF);
    chk("b2b_r_const", remainder, 32'hF);
    finish_div();

    for (int n = 0; n < 4; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == '0) rb = 32'd1;
      do_div(rs, ra, rb);
      finish_div();
    end

    // Reset in the middle of BUSY
    start = 1'b1; signed_div = 1'b0; dividend = 32'd77; divisor = 32'd5;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    chk("midrst_stall", {31'b0, stallreq_for_div}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      tick();
      @(negedge clk);
      chk("midrst_no_ready", {31'b0, ready}, 32'd0);
    end

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Sequencer for a multi-cycle radix-2 restoring divider used by DIV/DIVU in the EX stage.
- Accepts operands from EX and raises a stall request toward the pipeline stall controller for the whole operation.
- Iterates one quotient bit per cycle, then presents quotient (LO) and remainder (HI) with a one-cycle ready pulse.
- Supports cancellation when the instruction in EX is annulled.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  divide request. EX holds it high while the div instruction sits in EX, until ready is seen.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU. Sampled with start.
- dividend  input  WIDTH  rs operand. Sampled with start.
- divisor  input  WIDTH  rt operand. Sampled with start.
- annul  input  1  cancel the current operation (flush/exception).
- stallreq_for_div  output  1  to the stall controller; freezes PC..EX.
- ready  output  1  single-cycle pulse; results valid this cycle.
- quotient  output  WIDTH  LO write value.
- remainder  output  WIDTH  HI write value.

Behaviour:
- States: IDLE, DIVZERO, BUSY, DONE. All state and outputs update on posedge clk.
- Reset (rst=1, highest priority):
  - state=IDLE, iteration counter=0.
  - quotient=0, remainder=0, ready=0.
  - Internal shift/partial-remainder registers cleared.
- IDLE:
  - start=1, annul=0, divisor==0 -> DIVZERO.
  - start=1, annul=0, divisor!=0 -> BUSY. On entry:
    - Latch |dividend| and |divisor| (two's-complement absolute value if signed_div, raw otherwise).
    - Latch sign flags: neg_q = signed_div & (dividend[MSB] ^ divisor[MSB]); neg_r = signed_div & dividend[MSB].
    - Counter=0.
- BUSY:
  - Each cycle: shift partial remainder left 1 and bring in the next dividend bit (MSB first).
  - Trial subtract with a WIDTH+1-bit subtractor. If non-negative, keep the difference and set quotient bit=1; else keep and set 0.
  - Counter increments each cycle. After WIDTH iterations (counter==WIDTH-1 processed) -> DONE.
  - On that transition, apply signs: quotient=neg_q ? -q : q; remainder=neg_r ? -r : r (mod 2^WIDTH).
- DIVZERO:
  - One cycle, then DONE with quotient={WIDTH{1}}, remainder=dividend as latched. No exception is raised.
- DONE:
  - ready=1 for exactly this cycle; quotient/remainder stable.
  - Next state IDLE unconditionally.
  - The next div is accepted in the cycle after DONE if start is high then.
- Results: quotient/remainder hold their last value until the next DONE. They change only on entry to DONE, or on reset.
- stallreq_for_div = (state==IDLE & start & ~annul) | state==BUSY | state==DIVZERO. It is 0 in DONE, so the pipeline advances in the ready cycle.
- Latency, counted from the IDLE cycle T in which start is sampled:
  - Nonzero divisor: ready at T+WIDTH+1 (T+33).
  - Zero divisor: ready at T+2.
- annul:
  - Any state with annul=1 -> IDLE next cycle.
  - ready stays 0; quotient/remainder are not modified.
  - annul overrides start in the same cycle.
- Operand changes on dividend/divisor/signed_div after the start-sample cycle are ignored.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0 (natural wrap); no trap.
- Stall chain: this stall request is ORed into the pipeline stall bus by the stall controller. The EX stage register is not inserted with a bubble while stallreq_for_div is high.

Test Plan:
- Unsigned: start with dividend=100, divisor=7, signed_div=0 at T -> stallreq high T..T+32, ready only at T+33, quotient=14, remainder=2.
- Signed: dividend=0xFFFFFFF9 (-7), divisor=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also run 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: dividend=0x1234, divisor=0 at T -> ready at T+2, quotient=0xFFFFFFFF, remainder=0x1234, stallreq low at T+2.
- Annul mid-operation: start at T, annul=1 at T+10 -> IDLE at T+11, no ready pulse through T+40, quotient/remainder keep prior values.
- Signed overflow and back-to-back: 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Then, with start held high into the cycle after DONE, 0xFFFFFFFF/0x10 unsigned -> second ready 33 cycles after the re-sample, quotient=0x0FFFFFFF, remainder=0xF.
- Reset mid-BUSY: rst=1 at T+5 -> next cycle IDLE, quotient=0, remainder=0, ready=0, stallreq=0 with start low.
